// File: rtl/cam_pkg.sv
// cam_pkg: definitions shared by the camera capture path and the VGA reader.
//   - cam_state_e : capture FSM states
//   - CAM_WIDTH / CAM_HEIGHT : default frame geometry (160x120)
//   - RGB_* : field positions of a packed RGB444 word (R=[11:8], G=[7:4], B=[3:0])
//   - pack_rgb() : assembles a 12-bit pixel from its three nibbles
package cam_pkg;

  typedef enum logic [2:0] {
    WAIT_VS,
    WAIT_FRAME,
    IDLE_LINE,
    BYTE_HI,
    BYTE_LO
  } cam_state_e;

  localparam int CAM_WIDTH  = 160;
  localparam int CAM_HEIGHT = 120;

  localparam int RGB_R_MSB = 11;
  localparam int RGB_R_LSB = 8;
  localparam int RGB_G_MSB = 7;
  localparam int RGB_G_LSB = 4;
  localparam int RGB_B_MSB = 3;
  localparam int RGB_B_LSB = 0;

  function automatic logic [11:0] pack_rgb(input logic [3:0] r,
                                           input logic [3:0] g,
                                           input logic [3:0] b);
    logic [11:0] p;
    p = '0;
    p[RGB_R_MSB:RGB_R_LSB] = r;
    p[RGB_G_MSB:RGB_G_LSB] = g;
    p[RGB_B_MSB:RGB_B_LSB] = b;
    return p;
  endfunction

endpackage

// File: rtl/cam_sync_fsm.sv
// cam_sync_fsm: capture state register plus vsync/href decode.
// Ports:
//   clk, rst  : pixel clock, asynchronous active-high reset
//   vsync     : frame sync, high = vertical blanking (aborts any state)
//   href      : line valid
//   state     : current FSM state (debug / datapath qualifier)
//   latch_r   : this sample carries the first (XXXXRRRR) byte of a pixel
//   wr_px     : this sample carries the second (GGGGBBBB) byte; pixel complete
// latch_r and wr_px are decoded from the current state and the inputs of the
// same sample, so the datapath can register the write on that very edge.
module cam_sync_fsm
  import cam_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       href,
  output cam_state_e state,
  output logic       latch_r,
  output logic       wr_px
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_VS;
    end else if (vsync) begin
      // vsync wins over href in every state, including WAIT_VS.
      state <= WAIT_FRAME;
    end else begin
      case (state)
        WAIT_VS:    state <= WAIT_VS;
        WAIT_FRAME: state <= IDLE_LINE;
        IDLE_LINE:  state <= href ? BYTE_LO : IDLE_LINE;
        // A line that ends while waiting for the low byte drops the half pixel.
        BYTE_LO:    state <= href ? BYTE_HI : IDLE_LINE;
        BYTE_HI:    state <= href ? BYTE_LO : IDLE_LINE;
        default:    state <= WAIT_VS;
      endcase
    end
  end

  always_comb begin
    latch_r = 1'b0;
    wr_px   = 1'b0;
    if (!vsync && href) begin
      latch_r = (state == IDLE_LINE) || (state == BYTE_HI);
      wr_px   = (state == BYTE_LO);
    end
  end

endmodule

// File: rtl/cam_capture_rgb444.sv
// cam_capture_rgb444: pairs OV7670 RGB444 bytes into 12-bit pixels and writes
// them linearly into a WIDTH x HEIGHT dual-port frame buffer.
// Parameters: WIDTH (pixels/line), HEIGHT (lines/frame), AW (address width).
// Ports:
//   clk, rst        : pixel clock, asynchronous active-high reset
//   CAM_vsync       : frame sync (high = blanking)
//   CAM_href        : line valid
//   CAM_px_data     : pixel byte, XXXXRRRR then GGGGBBBB
//   DP_RAM_regW     : one-cycle write strobe
//   DP_RAM_addr_in  : write address (line*WIDTH + column)
//   DP_RAM_data_in  : pixel {R,G,B}
//   frame_done      : one-cycle pulse with the write to address WIDTH*HEIGHT-1
//   line_err        : only with CAM_CAPTURE_LINE_CHECK_EN defined; pulses on the
//                     first href-low sample after a window of != 2*WIDTH bytes
// Write contract: DP_RAM_regW is a valid-only strobe (the RAM port is always
// ready). Address and data are meaningful only in the strobe cycle and hold
// their last value otherwise; at most one strobe every two clocks.
module cam_capture_rgb444
  import cam_pkg::*;
#(
  parameter int WIDTH  = CAM_WIDTH,
  parameter int HEIGHT = CAM_HEIGHT,
  parameter int AW     = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [11:0]   DP_RAM_data_in,
  output logic          frame_done
`ifdef CAM_CAPTURE_LINE_CHECK_EN
  ,
  output logic          line_err
`endif
);

  // One extra bit so a full frame of exactly 2^AW pixels can still saturate.
  localparam logic [AW:0] TOTAL_C = (AW+1)'(WIDTH * HEIGHT);
  localparam logic [AW:0] LAST_C  = (AW+1)'(WIDTH * HEIGHT - 1);

  cam_state_e  fsm_state;
  logic        latch_r;
  logic        wr_px;
  logic [3:0]  r_lat;
  logic [AW:0] pix_cnt;

  cam_sync_fsm u_fsm (
    .clk     (clk),
    .rst     (rst),
    .vsync   (CAM_vsync),
    .href    (CAM_href),
    .state   (fsm_state),
    .latch_r (latch_r),
    .wr_px   (wr_px)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat          <= '0;
      pix_cnt        <= '0;
      DP_RAM_regW    <= 1'b0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      frame_done     <= 1'b0;
    end else begin
      DP_RAM_regW <= 1'b0;
      frame_done  <= 1'b0;
      if (latch_r) begin
        r_lat <= CAM_px_data[3:0];
      end
      if (fsm_state == WAIT_FRAME) begin
        // Held at zero until the vsync falling edge releases the FSM, so the
        // first pixel of every frame lands at address 0.
        pix_cnt <= '0;
      end else if (wr_px && (pix_cnt < TOTAL_C)) begin
        DP_RAM_regW    <= 1'b1;
        DP_RAM_addr_in <= pix_cnt[AW-1:0];
        DP_RAM_data_in <= pack_rgb(r_lat, CAM_px_data[7:4], CAM_px_data[3:0]);
        frame_done     <= (pix_cnt == LAST_C);
        // Stops at TOTAL_C: surplus lines write nothing and never wrap.
        pix_cnt        <= pix_cnt + 1'b1;
      end
    end
  end

`ifdef CAM_CAPTURE_LINE_CHECK_EN
  localparam int LBW = $clog2(2 * WIDTH + 2);
  localparam logic [LBW-1:0] LINE_BYTES = LBW'(2 * WIDTH);

  logic [LBW-1:0] line_bytes;
  logic           capturing;

  assign capturing = (fsm_state == IDLE_LINE) || (fsm_state == BYTE_HI) ||
                     (fsm_state == BYTE_LO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_bytes <= '0;
      line_err   <= 1'b0;
    end else begin
      line_err <= 1'b0;
      if (CAM_vsync || !capturing) begin
        // A window cut by vsync is not judged.
        line_bytes <= '0;
      end else if (CAM_href) begin
        if (line_bytes != '1) begin
          line_bytes <= line_bytes + 1'b1;
        end
      end else if (line_bytes != '0) begin
        line_err   <= (line_bytes != LINE_BYTES);
        line_bytes <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cam_capture_rgb444.sv
module tb_cam_capture_rgb444;
  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int AW     = 15;
  localparam int TOTAL  = WIDTH * HEIGHT;
  localparam int EW     = 1 + AW + 12;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          vsync;
  logic          href;
  logic [7:0]    px;
  logic          regw;
  logic [AW-1:0] addr;
  logic [11:0]   data;
  logic          fd;
`ifdef CAM_CAPTURE_LINE_CHECK_EN
  logic          lerr;
`endif

  always #5 clk = ~clk;

  cam_capture_rgb444 #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .CAM_vsync      (vsync),
    .CAM_href       (href),
    .CAM_px_data    (px),
    .DP_RAM_regW    (regw),
    .DP_RAM_addr_in (addr),
    .DP_RAM_data_in (data),
    .frame_done     (fd)
`ifdef CAM_CAPTURE_LINE_CHECK_EN
    ,
    .line_err       (lerr)
`endif
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            passed = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [7:0]    seq_q[$];
  int            exp_cnt = 0;
  bit            armed = 1'b0;
  int            fd_seen = 0;
`ifdef CAM_CAPTURE_LINE_CHECK_EN
  int            lerr_seen = 0;
  int            exp_lerr = 0;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (regw) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL wr_unexpected got addr=%0d data=%03h exp no write t=%0t", addr, data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr {fd,addr,data}", {4'b0, fd, addr, data}, {4'b0, mon_e});
        end
      end else if (fd) begin
        checks++;
        $display("FAIL fd_without_wr got fd=1 exp 0 t=%0t", $time);
      end
      if (fd) fd_seen++;
`ifdef CAM_CAPTURE_LINE_CHECK_EN
      if (lerr) lerr_seen++;
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      href = 1'b0;
      px   = 8'h00;
    end
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    href  = 1'b0;
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync   = 1'b0;
    armed   = 1'b1;
    exp_cnt = 0;
    idle(2);
  endtask

  task automatic push_px(input logic [3:0] r, input logic [7:0] gb);
    logic [AW-1:0] a;
    if (armed && exp_cnt < TOTAL) begin
      a = exp_cnt[AW-1:0];
      exp_q.push_back({(exp_cnt == TOTAL - 1), a, r, gb});
      exp_cnt++;
    end
  endtask

  task automatic fill_alt(input int n, input logic [7:0] b0, input logic [7:0] b1);
    seq_q.delete();
    for (int i = 0; i < n; i++) seq_q.push_back((i % 2 == 0) ? b0 : b1);
  endtask

  // Sends seq_q as one href window; abort_at >= 0 raises vsync on that byte.
  task automatic send_line(input int abort_at);
    logic [3:0] r;
    bit         aborted;
    bit         was_armed;
    r         = 4'h0;
    aborted   = 1'b0;
    was_armed = armed;
    for (int i = 0; i < seq_q.size(); i++) begin
      @(negedge clk);
      href = 1'b1;
      px   = seq_q[i];
      if (i == abort_at) begin
        vsync   = 1'b1;
        aborted = 1'b1;
        armed   = 1'b0;
      end
      if (!aborted) begin
        if (i % 2 == 0) r = px[3:0];
        else push_px(r, px);
      end
    end
    @(negedge clk);
    href = 1'b0;
    px   = 8'h00;
`ifdef CAM_CAPTURE_LINE_CHECK_EN
    if (was_armed && !aborted && seq_q.size() != 2 * WIDTH) exp_lerr++;
`else
    if (was_armed && aborted) was_armed = 1'b0;
`endif
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    vsync = 1'b0;
    href  = 1'b0;
    px    = 8'h00;
    repeat (3) @(negedge clk);
    check("reset regW", {31'b0, regw}, 32'd0);
    check("reset addr", {17'b0, addr}, 32'd0);
    check("reset data", {20'b0, data}, 32'd0);
    check("reset frame_done", {31'b0, fd}, 32'd0);
    rst = 1'b0;
    idle(2);

    // No vsync seen yet: the line must be ignored.
    fill_alt(4, 8'h12, 8'h34);
    send_line(-1);

    // Directed pixels in a fresh frame.
    vs_pulse();
    seq_q = '{8'hA5, 8'h3C};                 // 0x53C at address 0
    send_line(-1);
    seq_q = '{8'h12, 8'h34, 8'hFE, 8'hDC};   // 0x234, 0xEDC
    send_line(-1);
    fill_alt(321, 8'h0F, 8'hF0);              // 160 writes, odd byte dropped
    send_line(-1);
    seq_q = '{8'h01, 8'h02, 8'h03};          // 0x102, trailing byte dropped
    send_line(-1);

    // vsync abort at pixel 50 of line 10, then restart at address 0.
    vs_pulse();
    for (int row = 0; row < 10; row++) begin
      fill_alt(2 * WIDTH, 8'h07, 8'h8E);
      send_line(-1);
    end
    fill_alt(2 * WIDTH, 8'h07, 8'h8E);
    send_line(100);
    idle(4);
    @(negedge clk);
    vsync   = 1'b0;
    armed   = 1'b1;
    exp_cnt = 0;
    idle(2);
    seq_q = '{8'h0A, 8'hBC, 8'h07, 8'h89};   // 0xABC @0, 0x789 @1
    send_line(-1);

    // Reset while waiting for a low byte.
    @(negedge clk); href = 1'b1; px = 8'h01;
    @(negedge clk); px = 8'h23; push_px(4'h1, 8'h23);   // 0x123 @2
    @(negedge clk); px = 8'h04;
    @(negedge clk);
    check("addr before reset", {17'b0, addr}, 32'd2);
    check("data before reset", {20'b0, data}, 32'h123);
    rst   = 1'b1;
    href  = 1'b0;
    armed = 1'b0;
    #1;
    check("async reset regW", {31'b0, regw}, 32'd0);
    check("async reset addr", {17'b0, addr}, 32'd0);
    check("async reset data", {20'b0, data}, 32'd0);
    check("async reset frame_done", {31'b0, fd}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fill_alt(4, 8'h0F, 8'hF0);
    send_line(-1);
    send_line(-1);
    vs_pulse();
    seq_q = '{8'hA5, 8'h3C};                 // 0x53C @0 after new vsync
    send_line(-1);

    // Oversized frame: 124 full lines, writes stop after the last address.
    vs_pulse();
    for (int row = 0; row < 124; row++) begin
      fill_alt(2 * WIDTH, 8'h0F, 8'hF0);
      send_line(-1);
    end
    idle(4);
    check("addr held at last", {17'b0, addr}, TOTAL - 1);
    check("data held at last", {20'b0, data}, 32'hFF0);
    check("frame_done count", fd_seen, 32'd1);
    check("expected queue drained", exp_q.size(), 32'd0);
`ifdef CAM_CAPTURE_LINE_CHECK_EN
    check("line_err pulses", lerr_seen, exp_lerr);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
